// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit with architectural HI/LO registers
// Fixed-latency mult/div driven by a Start strobe; mthi/mtlo write HI/LO directly.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Data1,
    input  logic [31:0] Data2,
    input  logic        Start,
    input  logic [2:0]  md_op,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   a, b;
    logic [1:0]    op;
    logic [63:0]   prod;
    logic [31:0]   ma, mb, q, r, quo, rem;
    logic          sgn;
    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap
    always_comb begin
        sgn  = op == 2'b10;
        prod = op[0] ? {32'b0, a} * {32'b0, b} : {{32{a[31]}}, a} * {{32{b[31]}}, b};
        ma   = sgn && a[31] ? -a : a;
        mb   = sgn && b[31] ? -b : b;
        q    = mb == 32'd0 ? 32'd0 : ma / mb;
        r    = mb == 32'd0 ? 32'd0 : ma % mb;
        quo  = sgn && (a[31] ^ b[31]) ? -q : q;
        rem  = sgn && a[31] ? -r : r;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
            op    <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == IDLE) begin
            if (Start && !md_op[2]) begin
                a     <= Data1;
                b     <= Data2;
                op    <= md_op[1:0];
                cnt   <= md_op[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                state <= RUN;
                busy  <= 1'b1;
            end else if (Start && md_op == 3'b100) begin
                hi <= Data1;
            end else if (Start && md_op == 3'b101) begin
                lo <= Data1;
            end
        end else if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!op[1]) begin
                {hi, lo} <= prod;
            end else if (b != 32'd0) begin
                hi <= rem;
                lo <= quo;
            end
        end else begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench for mult_div_unit
// Reference model computes HI/LO with 64-bit integer arithmetic.
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Data1, Data2;
    logic        Start;
    logic [2:0]  md_op;
    logic [31:0] hi, lo;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Data1(Data1), .Data2(Data2),
        .Start(Start), .md_op(md_op), .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = 64'(sx * sy); {h, l} = p; end
            3'd1: begin p = 64'(x) * 64'(y); {h, l} = p; end
            3'd2: if (y != 0) begin l = 32'(sx / sy); h = 32'(sx % sy); end
            3'd3: if (y != 0) begin l = x / y; h = x % y; end
            3'd4: h = x;
            3'd5: l = x;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        Data1 = x;
        Data2 = y;
        md_op = o;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Data1 = $urandom;
        Data2 = $urandom;
    endtask

    task automatic check_hilo(input string name);
        checks++;
        if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0", name, hi, lo, busy, exp_hi, exp_lo);
        end
    endtask

    // inj: 0 none, 1 random Start pulses while busy, 2 mthi 0xAB at busy cycle 2 and the final cycle
    task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int inj);
        int n = o[1] ? DC : MC;
        int cnt = 0;
        logic [31:0] nh = exp_hi;
        logic [31:0] nl = exp_lo;
        model(o, x, y, nh, nl);
        start_op(o, x, y);
        while (busy === 1'b1 && cnt < 200) begin
            checks++;
            if (hi !== exp_hi || lo !== exp_lo) begin
                errors++;
                $display("FAIL hold op=%0d cyc=%0d: hi=%h lo=%h expected hi=%h lo=%h", o, cnt, hi, lo, exp_hi, exp_lo);
            end
            if (inj == 1) begin
                Start = 1'($urandom_range(0, 1));
                md_op = 3'($urandom);
                Data1 = $urandom;
                Data2 = $urandom;
            end else if (inj == 2) begin
                Start = (cnt == 1 || cnt == n - 1);
                md_op = 3'b100;
                Data1 = 32'hAB;
            end
            cnt++;
            tick();
        end
        Start = 1'b0;
        checks++;
        if (cnt != n) begin
            errors++;
            $display("FAIL busy_len op=%0d: got %0d cycles expected %0d", o, cnt, n);
        end
        exp_hi = nh;
        exp_lo = nl;
        check_hilo($sformatf("result op=%0d a=%h b=%h", o, x, y));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Start = 1'b0;
        md_op = 3'd0;
        Data1 = $urandom;
        Data2 = $urandom;
        #2;
        check_hilo("reset_state");
        tick();
        reset = 1'b0;
        tick();
        check_hilo("after_reset_release");
    endtask

    task automatic test_directed();
        run_md(3'd0, 32'hFFFF_FFFF, 32'd2, 0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mult_lit: hi=%h lo=%h expected hi=ffffffff lo=fffffffe", hi, lo);
        end
        run_md(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
        checks++;
        if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL multu_lit: hi=%h lo=%h expected hi=00000001 lo=fffffffe", hi, lo);
        end
        run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_lit: hi=%h lo=%h expected hi=ffffffff lo=fffffffd", hi, lo);
        end
        run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_ovf: hi=%h lo=%h expected hi=00000000 lo=80000000", hi, lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        start_op(3'd4, 32'h11, 32'd0);
        exp_hi = 32'h11;
        check_hilo("mthi");
        start_op(3'd5, 32'h22, 32'd0);
        exp_lo = 32'h22;
        check_hilo("mtlo");
        start_op(3'd6, 32'h55, 32'h66);
        check_hilo("reserved6");
        start_op(3'd7, 32'h77, 32'h88);
        check_hilo("reserved7");
        for (int i = 0; i < 3; i++) begin
            Data1 = $urandom;
            md_op = 3'($urandom);
            tick();
        end
        check_hilo("idle_no_start");
    endtask

    task automatic test_div_zero();
        run_md(3'd3, 32'd7, 32'd0, 0);
        checks++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            errors++;
            $display("FAIL divu_zero: hi=%h lo=%h expected hi=00000011 lo=00000022", hi, lo);
        end
        run_md(3'd2, 32'hFFFF_FFF0, 32'd0, 0);
    endtask

    task automatic test_ignore_busy();
        run_md(3'd1, 32'd3, 32'd4, 2);
        checks++;
        if (hi !== 32'h0 || lo !== 32'hC) begin
            errors++;
            $display("FAIL ignore_mthi: hi=%h lo=%h expected hi=00000000 lo=0000000c", hi, lo);
        end
        start_op(3'd4, 32'h1234, 32'd0);
        exp_hi = 32'h1234;
        check_hilo("mthi_1234");
        for (int i = 0; i < 4; i++) run_md(3'($urandom_range(0, 3)), pick(), pick(), 1);
    endtask

    task automatic test_reset_mid_op();
        start_op(3'd2, 32'd100, 32'd7);
        for (int i = 0; i < 3; i++) tick();
        #3;
        reset = 1'b1;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check_hilo("async_reset_mid_div");
        #1;
        reset = 1'b0;
        for (int i = 0; i < DC + 3; i++) tick();
        check_hilo("no_commit_after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [2:0] o = 3'($urandom);
            logic [31:0] x = pick();
            logic [31:0] y = pick();
            if (!o[2]) begin
                run_md(o, x, y, int'($urandom_range(0, 1)));
            end else begin
                model(o, x, y, exp_hi, exp_lo);
                start_op(o, x, y);
                check_hilo($sformatf("rand_mt op=%0d", o));
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_hi = hi === exp_hi ? exp_hi : exp_hi;
        run_md(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
        run_md(3'd3, 32'hFFFF_FFFF, 32'd10, 0);
        run_md(3'd0, 32'h8000_0000, 32'h8000_0000, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_div_zero();
        test_ignore_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
